// File: rtl/xmem_arb_pkg.sv
// Shared types and widths for the xmem round-robin arbiter.
package xmem_arb_pkg;

  localparam int XMEM_AW     = 30;
  localparam int XMEM_DW     = 32;
  localparam int XMEM_SW     = 4;
  localparam int MAX_MASTERS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/xmem_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last_i`,
// wrapping NUM_MASTERS-1 -> 0.
module xmem_rr_pick #(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [1:0]             last_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [1:0]             idx_o,
  output logic                   valid_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves one unassigned (no latch).
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      if (!valid_o && req_i[(int'(last_i) + off) % NUM_MASTERS]) begin
        valid_o = 1'b1;
        gnt_o[(int'(last_i) + off) % NUM_MASTERS] = 1'b1;
        idx_o = 2'((int'(last_i) + off) % NUM_MASTERS);
      end
    end
  end

endmodule

// File: rtl/xmem_arbiter.sv
// Round-robin arbiter sharing the xmem Wishbone slave port; grant held for the owner's whole cyc.
// Optional stuck-slave abort is enabled by defining XMEM_ARB_TIMEOUT_EN.
module xmem_arbiter
  import xmem_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [XMEM_AW*NUM_MASTERS-1:0] m_adr_i,
  input  logic [XMEM_DW*NUM_MASTERS-1:0] m_dat_i,
  input  logic [XMEM_SW*NUM_MASTERS-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]         m_we_i,
  input  logic [NUM_MASTERS-1:0]         m_stb_i,
  input  logic [NUM_MASTERS-1:0]         m_cyc_i,
  output logic [NUM_MASTERS-1:0]         m_ack_o,
  output logic [NUM_MASTERS-1:0]         m_err_o,
  output logic [XMEM_DW-1:0]             m_dat_o,
  output logic [XMEM_AW-1:0]             s_adr_o,
  output logic [XMEM_DW-1:0]             s_dat_o,
  output logic [XMEM_SW-1:0]             s_sel_o,
  output logic                           s_we_o,
  output logic                           s_stb_o,
  output logic                           s_cyc_o,
  input  logic [XMEM_DW-1:0]             s_dat_i,
  input  logic                           s_ack_i,
  output logic [NUM_MASTERS-1:0]         grant_o
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_masters
    $error("xmem_arbiter: NUM_MASTERS must be 2..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("xmem_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  localparam logic [1:0] LAST_RST = 2'(NUM_MASTERS - 1);

  state_e                 state_q, state_d;
  logic [1:0]             owner_q, owner_d;
  logic [1:0]             last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [1:0]             pick_idx;
  logic                   pick_valid;

  // Per-master buses unpacked to MAX_MASTERS entries so the 2-bit owner index always fits.
  logic [XMEM_AW-1:0]     adr_a [MAX_MASTERS];
  logic [XMEM_DW-1:0]     dat_a [MAX_MASTERS];
  logic [XMEM_SW-1:0]     sel_a [MAX_MASTERS];
  logic [MAX_MASTERS-1:0] we_a, stb_a, cyc_a;

  always_comb begin
    we_a  = '0;
    stb_a = '0;
    cyc_a = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      adr_a[i] = '0;
      dat_a[i] = '0;
      sel_a[i] = '0;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      adr_a[i] = m_adr_i[(NUM_MASTERS-1-i)*XMEM_AW +: XMEM_AW];
      dat_a[i] = m_dat_i[(NUM_MASTERS-1-i)*XMEM_DW +: XMEM_DW];
      sel_a[i] = m_sel_i[(NUM_MASTERS-1-i)*XMEM_SW +: XMEM_SW];
      we_a[i]  = m_we_i[i];
      stb_a[i] = m_stb_i[i];
      cyc_a[i] = m_cyc_i[i];
    end
  end

  xmem_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  logic own_cyc, own_stb, active;
  assign own_cyc = cyc_a[owner_q];
  assign own_stb = stb_a[owner_q];
  assign active  = (state_q == GRANT);

  assign s_cyc_o = active & own_cyc;
  assign s_stb_o = active & own_cyc & own_stb;
  assign s_adr_o = adr_a[owner_q];
  assign s_dat_o = dat_a[owner_q];
  assign s_sel_o = sel_a[owner_q];
  assign s_we_o  = we_a[owner_q];
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  // Acks are dropped while reset is high so an aborted owner never sees a late completion.
  assign m_ack_o = (s_stb_o && s_ack_i && !reset) ? grant_q : '0;

`ifdef XMEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  assign m_err_o = (err_q && !reset) ? grant_q : '0;
`else
  assign m_err_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
`ifdef XMEM_ARB_TIMEOUT_EN
    tmo_d = (s_ack_i || !s_stb_o) ? 8'd0 : tmo_q + 8'd1;
    err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          grant_d = pick_gnt;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          last_d  = owner_q;
          grant_d = '0;
          state_d = IDLE;
        end
`ifdef XMEM_ARB_TIMEOUT_EN
        else if (tmo_d == TMO_LIMIT) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end
`endif
      end
`ifdef XMEM_ARB_TIMEOUT_EN
      DRAIN: begin
        // Slave stays deasserted; the grant is only released once the owner gives up cyc.
        if (!own_cyc) begin
          last_d  = owner_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      grant_q <= '0;
`ifdef XMEM_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
`ifdef XMEM_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
